antares_hilo_controller: RTL and testbench
==========================================

Name: antares_hilo_controller

Overview:
- Sequences the 4-stage pipelined 32x32 multiplier for the EX stage and owns the architectural HI/LO registers.
- Functions: issues multiplies, captures results, performs MADD/MSUB accumulation, serves MFHI/MFLO/MTHI/MTLO, and stalls the pipeline while an operation is in flight.
- Sits between the EX stage, the hazard detection unit, and the multiplier instance.

Parameters:
- MULT_LATENCY, 4: cycles from issue to expected mult_ready; used by the timeout watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_hilo_op  in  4  op code: 0 NOP, 1 MULT, 2 MULTU, 3 MADD, 4 MADDU, 5 MSUB, 6 MSUBU, 7 MTHI, 8 MTLO, 9 MFHI, 10 MFLO; 11-15 are treated as NOP
- ex_rs_data  in  32  operand A, and data for MTHI/MTLO
- ex_rt_data  in  32  operand B
- ex_stall  in  1  EX stage frozen this cycle
- flush  in  1  abort the current/in-flight op
- mult_result  in  64  signed-corrected product from the multiplier
- mult_ready  in  1  product valid
- mult_active  in  1  multiplier pipeline occupied
- mult_input_a  out  32  = ex_rs_data
- mult_input_b  out  32  = ex_rt_data
- mult_signed_op  out  1  1 for ops 1, 3, 5
- mult_enable_op  out  1  issue pulse
- mult_stall  out  1  multiplier freeze
- mult_flush  out  1  multiplier flush
- hilo_stall  out  1  stall request to the hazard detection unit
- hilo_rdata  out  32  MFHI/MFLO read data
- hilo_error  out  1  one-cycle watchdog pulse
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state IDLE, hi=0, lo=0, product latch=0, counter=0, hilo_error=0.
- Combinational outputs: all combinational outputs are inactive under rst.
- States:
  - IDLE: no op in flight.
  - BUSY: waiting for mult_ready.
  - ACCUM: one-cycle add/sub into HI/LO.
- issue = (ex_hilo_op in 1..6) & IDLE & ~ex_stall & ~flush.
  - mult_enable_op = issue.
  - On issue, latch the op kind and go IDLE->BUSY.
- BUSY with mult_ready:
  - MULT/MULTU: {hi,lo} <= mult_result, go to IDLE.
  - MADD/MSUB class: latch the product, go to ACCUM.
- ACCUM: {hi,lo} <= {hi,lo} + product (MADD/MADDU) or - product (MSUB/MSUBU), 64-bit modulo 2^64, then go to IDLE.
- Latency:
  - Issue in cycle T; mult_ready in cycle T+4.
  - MULT/MULTU result is visible on hi/lo in T+5.
  - MADD/MSUB result is visible in T+6.
- hilo_stall = (ex_hilo_op in 1..10) & state != IDLE. The stalled op is re-presented by EX and issues/executes in the first IDLE cycle.
- Move ops in IDLE:
  - MTHI/MTLO with ~ex_stall & ~flush: write hi/lo at the next edge.
  - MFHI/MFLO: hilo_rdata = hi/lo combinationally, zero latency.
  - hilo_rdata = 0 for any other op.
- Back-to-back MULT in consecutive cycles: the second op stalls until IDLE; there is no overlap.
- mult_stall = 0 whenever state != IDLE or issue (the multiplier always drains). Otherwise it is governed by the optional feature.
- flush:
  - mult_flush = flush.
  - Any state -> IDLE; in-flight result discarded; hi/lo unchanged; MTHI/MTLO in the same cycle suppressed.
- Watchdog:
  - A counter runs in BUSY.
  - If it reaches MULT_LATENCY+2 without mult_ready: pulse hilo_error, go to IDLE, hi/lo unchanged.
- mult_ready outside BUSY is ignored.
- Reset mid-operation: rst has priority over flush and all else; HI/LO cleared.

Optional Feature:
- Macro: ANTARES_HILO_MADD_EN.
- Defined:
  - MADD/MADDU/MSUB/MSUBU behave as above.
  - mult_stall is unaffected.
- Undefined:
  - Ops 3-6 are treated as NOP: no issue, no stall, HI/LO unchanged.
  - The ACCUM state is not built.
  - mult_stall = 1 in IDLE without issue (idle power saving).

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=0x00000003 -> mult_enable_op in T; hilo_stall on a following MFLO during T+1..T+4; hi=0xFFFFFFFF, lo=0xFFFFFFFA in T+5.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at T+5; mult_signed_op=0 at issue.
- MTHI 0, MTLO 10, then MSUB rs=4, rt=5 (macro defined) -> hi=0xFFFFFFFF, lo=0xFFFFFFF6 at T+6. Same sequence with the macro undefined -> hi=0, lo=10, no stall.
- MULT issued, flush in T+2 -> mult_flush=1, state IDLE in T+3, hi/lo keep their prior values; a later MFHI returns the old HI with no stall.
- MULT issued, ex_stall held high throughout -> the result is still captured at T+5; no second issue while ex_stall=1.
- mult_ready forced low after issue -> hilo_error pulses once at count 6, state IDLE, hi/lo unchanged; rst asserted in BUSY -> hi=lo=0 next cycle, hilo_stall=0.

Source files
------------

// File: rtl/antares_hilo_controller.sv
// -----------------------------------------------------------------------------
// antares_hilo_controller
//
// Purpose:
//   Sequences the external 4-stage pipelined 32x32 multiplier on behalf of the
//   EX stage and owns the architectural HI/LO registers. It issues multiplies,
//   captures products, optionally accumulates (MADD/MSUB family), serves
//   MTHI/MTLO/MFHI/MFLO, and asks the hazard unit to stall while busy.
//
// Configuration macro:
//   ANTARES_HILO_MADD_EN - when defined, ops 3..6 (MADD/MADDU/MSUB/MSUBU) are
//   executed through a one-cycle ACCUM state. When undefined they decode as NOP,
//   the ACCUM state is not built, and the multiplier is frozen (mult_stall=1)
//   while idle to save power.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ex_hilo_op[3:0]     0 NOP,1 MULT,2 MULTU,3 MADD,4 MADDU,5 MSUB,6 MSUBU,
//                       7 MTHI,8 MTLO,9 MFHI,10 MFLO, 11..15 NOP
//   ex_rs_data/rt_data  operands (rs also carries MTHI/MTLO data)
//   ex_stall, flush     EX frozen / abort current and in-flight op
//   mult_result/ready/active   multiplier return path
//   mult_input_a/b, mult_signed_op, mult_enable_op, mult_stall, mult_flush
//                       multiplier control
//   hilo_stall          stall request to hazard detection
//   hilo_rdata          MFHI/MFLO read data (zero latency)
//   hilo_error          one-cycle watchdog pulse
//   hi, lo              architectural HI/LO
//   dbg_state_o         current FSM state (0 IDLE, 1 BUSY, 2 ACCUM)
//
// Handshake: mult_enable_op is a single-cycle issue pulse, only raised while
// IDLE; the multiplier answers with a single-cycle mult_ready. A mult_ready
// that arrives when not BUSY (e.g. after a flush or watchdog abort) is dropped.
// -----------------------------------------------------------------------------
module antares_hilo_controller #(
  parameter int MULT_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ex_hilo_op,
  input  logic [31:0] ex_rs_data,
  input  logic [31:0] ex_rt_data,
  input  logic        ex_stall,
  input  logic        flush,
  input  logic [63:0] mult_result,
  input  logic        mult_ready,
  input  logic        mult_active,
  output logic [31:0] mult_input_a,
  output logic [31:0] mult_input_b,
  output logic        mult_signed_op,
  output logic        mult_enable_op,
  output logic        mult_stall,
  output logic        mult_flush,
  output logic        hilo_stall,
  output logic [31:0] hilo_rdata,
  output logic        hilo_error,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state_o
);

  localparam int CW = $clog2(MULT_LATENCY + 3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ACCUM = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
`ifdef ANTARES_HILO_MADD_EN
  logic [63:0]     prod_q, prod_d;
  logic            acc_q, acc_d;
  logic            sub_q, sub_d;
`endif

  logic op_mul, op_acc, op_issue, op_hilo, issue, is_idle;

  // Op decode; the accumulate family only exists when the feature is built.
  always_comb begin
    op_mul = (ex_hilo_op == 4'd1) || (ex_hilo_op == 4'd2);
`ifdef ANTARES_HILO_MADD_EN
    op_acc = (ex_hilo_op >= 4'd3) && (ex_hilo_op <= 4'd6);
`else
    op_acc = 1'b0;
`endif
    op_issue = op_mul || op_acc;
    op_hilo  = op_issue || ((ex_hilo_op >= 4'd7) && (ex_hilo_op <= 4'd10));
  end

  assign is_idle = (state_q == IDLE);
  assign issue   = op_issue && is_idle && !ex_stall && !flush;

  // Next-state and HI/LO update.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`ifdef ANTARES_HILO_MADD_EN
    prod_d  = prod_q;
    acc_d   = acc_q;
    sub_d   = sub_q;
`endif
    if (flush) begin
      // Abort anything in flight; HI/LO are left as they are.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            state_d = BUSY;
            cnt_d   = '0;
`ifdef ANTARES_HILO_MADD_EN
            acc_d   = op_acc;
            sub_d   = (ex_hilo_op == 4'd5) || (ex_hilo_op == 4'd6);
`endif
          end else if (!ex_stall) begin
            if (ex_hilo_op == 4'd7) hi_d = ex_rs_data;
            if (ex_hilo_op == 4'd8) lo_d = ex_rs_data;
          end
        end
        BUSY: begin
          if (mult_ready) begin
`ifdef ANTARES_HILO_MADD_EN
            if (acc_q) begin
              prod_d  = mult_result;
              state_d = ACCUM;
            end else begin
              {hi_d, lo_d} = mult_result;
              state_d      = IDLE;
            end
`else
            {hi_d, lo_d} = mult_result;
            state_d      = IDLE;
`endif
          end else if (cnt_q == CW'(MULT_LATENCY + 1)) begin
            // Counter would reach MULT_LATENCY+2 with no product: give up.
            err_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef ANTARES_HILO_MADD_EN
        ACCUM: begin
          if (sub_q) {hi_d, lo_d} = {hi_q, lo_q} - prod_q;
          else       {hi_d, lo_d} = {hi_q, lo_q} + prod_q;
          state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef ANTARES_HILO_MADD_EN
      prod_q  <= '0;
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef ANTARES_HILO_MADD_EN
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      sub_q   <= sub_d;
`endif
    end
  end

  // Combinational outputs, all forced inactive during reset.
  always_comb begin
    mult_input_a   = '0;
    mult_input_b   = '0;
    mult_signed_op = 1'b0;
    mult_enable_op = 1'b0;
    mult_stall     = 1'b0;
    mult_flush     = 1'b0;
    hilo_stall     = 1'b0;
    hilo_rdata     = '0;
    if (!rst) begin
      mult_input_a   = ex_rs_data;
      mult_input_b   = ex_rt_data;
      mult_signed_op = (ex_hilo_op == 4'd1) ||
                       (op_acc && ((ex_hilo_op == 4'd3) || (ex_hilo_op == 4'd5)));
      mult_enable_op = issue;
      mult_flush     = flush;
      hilo_stall     = op_hilo && !is_idle;
`ifdef ANTARES_HILO_MADD_EN
      mult_stall     = 1'b0;
`else
      // Freeze the multiplier while nothing is in flight or being issued.
      mult_stall     = is_idle && !issue;
`endif
      if (is_idle && (ex_hilo_op == 4'd9))  hilo_rdata = hi_q;
      if (is_idle && (ex_hilo_op == 4'd10)) hilo_rdata = lo_q;
    end
  end

  assign hilo_error  = err_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state_o = state_q;

  // Occupancy is implied by the FSM; the multiplier's own view is not needed.
  logic unused_ok;
  assign unused_ok = mult_active;

endmodule

// File: tb/tb_antares_hilo_controller.sv
module tb_antares_hilo_controller;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  ex_hilo_op;
  logic [31:0] ex_rs_data, ex_rt_data;
  logic        ex_stall, flush;
  logic [63:0] mult_result;
  logic        mult_ready, mult_active;
  logic [31:0] mult_input_a, mult_input_b;
  logic        mult_signed_op, mult_enable_op, mult_stall, mult_flush;
  logic        hilo_stall, hilo_error;
  logic [31:0] hilo_rdata, hi, lo;
  logic [1:0]  dbg_state;

  antares_hilo_controller #(.MULT_LATENCY(4)) dut (
    .clk(clk), .rst(rst), .ex_hilo_op(ex_hilo_op), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_stall(ex_stall), .flush(flush),
    .mult_result(mult_result), .mult_ready(mult_ready), .mult_active(mult_active),
    .mult_input_a(mult_input_a), .mult_input_b(mult_input_b),
    .mult_signed_op(mult_signed_op), .mult_enable_op(mult_enable_op),
    .mult_stall(mult_stall), .mult_flush(mult_flush), .hilo_stall(hilo_stall),
    .hilo_rdata(hilo_rdata), .hilo_error(hilo_error), .hi(hi), .lo(lo),
    .dbg_state_o(dbg_state)
  );

  // ---------------- multiplier model: 4-cycle pipe ----------------
  logic        kill_ready;
  logic [3:0]  rdy_pipe;
  logic [63:0] prod_pipe [4];

  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  always @(posedge clk) begin
    rdy_pipe     <= {rdy_pipe[2:0], mult_enable_op};
    prod_pipe[0] <= mul64(mult_input_a, mult_input_b, mult_signed_op);
    for (int i = 1; i < 4; i++) prod_pipe[i] <= prod_pipe[i-1];
  end
  assign mult_ready  = rdy_pipe[3] & ~kill_ready;
  assign mult_result = prod_pipe[3];
  assign mult_active = |rdy_pipe;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_hilo(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {hi, lo}, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic move_op(input logic [3:0] op, input logic [31:0] d);
    ex_hilo_op = op; ex_rs_data = d;
    tick();
    ex_hilo_op = 4'd0;
  endtask

  // Issue in cycle T, then present 'follow' (a stalling op) for busy_cycles.
  task automatic issue_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic exp_sgn, input logic [3:0] follow,
                          input logic follow_stall, input int busy_cycles);
    ex_hilo_op = op; ex_rs_data = a; ex_rt_data = b; #1;
    chk("issue_en", mult_enable_op, 1'b1);
    chk("issue_sgn", mult_signed_op, exp_sgn);
    chk("issue_in_a", mult_input_a, a);
    chk("issue_mstall", mult_stall, 1'b0);
    tick();
    ex_hilo_op = follow; ex_stall = follow_stall;
    for (int i = 0; i < busy_cycles; i++) begin
      #1;
      chk("busy_stall", hilo_stall, 1'b1);
      chk("busy_no_issue", mult_enable_op, 1'b0);
      chk("busy_no_err", hilo_error, 1'b0);
      chk("busy_rdata", hilo_rdata, 32'd0);
      tick();
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; ex_hilo_op = 4'd1; ex_rs_data = 32'h1234; ex_rt_data = 32'h5678;
    ex_stall = 1'b0; flush = 1'b0; kill_ready = 1'b0;
    rdy_pipe = '0;
    tick(); tick();
    chk("rst_en", mult_enable_op, 1'b0);
    chk("rst_in_a", mult_input_a, 32'd0);
    chk("rst_mstall", mult_stall, 1'b0);
    rst = 1'b0; ex_hilo_op = 4'd0;
    #1;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_err", hilo_error, 1'b0);
`ifdef ANTARES_HILO_MADD_EN
    chk("idle_mstall", mult_stall, 1'b0);
`else
    chk("idle_mstall", mult_stall, 1'b1);
`endif

    // MULT -2 * 3, MFLO follows and stalls T+1..T+4
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFA);
    issue_op(4'd1, 32'hFFFFFFFE, 32'h3, 1'b1, 4'd10, 1'b0, 4);
    #1;
    chk_hilo("mult_signed");
    chk("mult_mflo_nostall", hilo_stall, 1'b0);
    chk("mult_mflo_data", hilo_rdata, 32'hFFFFFFFA);
    ex_hilo_op = 4'd0; tick();

    // MULTU max * max
    exp_q.push_back(64'hFFFFFFFE_00000001);
    issue_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'd9, 1'b0, 4);
    #1;
    chk_hilo("multu");
    chk("multu_mfhi", hilo_rdata, 32'hFFFFFFFE);
    ex_hilo_op = 4'd0; tick();

    // MTHI 0, MTLO 10, MSUB 4*5
    move_op(4'd7, 32'd0);
    move_op(4'd8, 32'd10);
    chk("mt_hilo", {hi, lo}, {32'd0, 32'd10});
`ifdef ANTARES_HILO_MADD_EN
    exp_q.push_back(64'hFFFFFFFF_FFFFFFF6);
    issue_op(4'd5, 32'd4, 32'd5, 1'b1, 4'd10, 1'b0, 5);
    #1;
    chk_hilo("msub");
    // MADDU wraps back through 2^64
    exp_q.push_back({32'd0, 32'd10});
    issue_op(4'd4, 32'd4, 32'd5, 1'b0, 4'd10, 1'b0, 5);
    #1;
    chk_hilo("maddu_wrap");
`else
    ex_hilo_op = 4'd5; ex_rs_data = 32'd4; ex_rt_data = 32'd5; #1;
    chk("msub_nop_en", mult_enable_op, 1'b0);
    chk("msub_nop_mstall", mult_stall, 1'b1);
    tick();
    chk("msub_nop_hstall", hilo_stall, 1'b0);
    chk("msub_nop_state", dbg_state, 2'd0);
    repeat (6) tick();
    chk("msub_nop_hilo", {hi, lo}, {32'd0, 32'd10});
`endif
    ex_hilo_op = 4'd0; tick();

    // Flush in T+2; stale mult_ready at T+4 must be ignored
    move_op(4'd7, 32'h11111111);
    move_op(4'd8, 32'h22222222);
    exp_q.push_back(64'h11111111_22222222);
    issue_op(4'd1, 32'd7, 32'd9, 1'b1, 4'd9, 1'b0, 1);
    flush = 1'b1; ex_hilo_op = 4'd0; #1;
    chk("flush_out", mult_flush, 1'b1);
    tick();
    flush = 1'b0;
    chk("flush_state", dbg_state, 2'd0);
    repeat (4) tick();
    chk("flush_stale_state", dbg_state, 2'd0);
    chk_hilo("flush_keep");
    ex_hilo_op = 4'd9; #1;
    chk("flush_mfhi_stall", hilo_stall, 1'b0);
    chk("flush_mfhi_data", hilo_rdata, 32'h11111111);
    ex_hilo_op = 4'd7; ex_rs_data = 32'hDEADBEEF; flush = 1'b1;
    tick();
    flush = 1'b0; ex_hilo_op = 4'd0;
    chk("flush_mthi_supp", hi, 32'h11111111);

    // ex_stall held after issue; result still captured, no re-issue
    exp_q.push_back(64'h00000001_00000000);
    issue_op(4'd1, 32'h00010000, 32'h00010000, 1'b1, 4'd1, 1'b1, 4);
    #1;
    chk_hilo("stall_capture");
    chk("stall_state", dbg_state, 2'd0);
    chk("stall_no_reissue", mult_enable_op, 1'b0);
    tick();
    chk("stall_no_reissue2", mult_enable_op, 1'b0);
    ex_hilo_op = 4'd0; ex_stall = 1'b0; tick();

    // Watchdog: no mult_ready
    kill_ready = 1'b1;
    exp_q.push_back(64'h00000001_00000000);
    issue_op(4'd1, 32'd3, 32'd3, 1'b1, 4'd9, 1'b0, 6);
    chk("wd_err", hilo_error, 1'b1);
    chk("wd_state", dbg_state, 2'd0);
    chk_hilo("wd_keep");
    ex_hilo_op = 4'd0;
    tick();
    chk("wd_err_pulse", hilo_error, 1'b0);

    // Reset while BUSY
    issue_op(4'd2, 32'd5, 32'd6, 1'b0, 4'd9, 1'b0, 2);
    chk("rst_busy_state", dbg_state, 2'd1);
    rst = 1'b1; #1;
    chk("rst_busy_hstall", hilo_stall, 1'b0);
    tick();
    rst = 1'b0; #1;
    chk("rst_busy_hilo", {hi, lo}, 64'd0);
    chk("rst_busy_state2", dbg_state, 2'd0);
    chk("rst_busy_hstall2", hilo_stall, 1'b0);
    kill_ready = 1'b0; ex_hilo_op = 4'd0;
    repeat (6) tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
